// File: rtl/pkt_id_manager_pkg.sv
// Shared constants and sim-only message macros
// for the packet-ID free-list manager.
`ifndef PKT_ID_MANAGER_PKG_SV
`define PKT_ID_MANAGER_PKG_SV

`define HTERMINATE(msg) $fatal(1, msg)
`define HDISPLAY(msg) $info(msg)

package pkt_id_manager_pkg;

  localparam int PKT_NUM    = 512;
  localparam int PKT_AWIDTH = $clog2(PKT_NUM);
  localparam int INIT_DELAY = 50;

endpackage

`endif

// File: rtl/pkt_id_manager_free_id_fifo.sv
// Show-ahead FIFO of free packet IDs: memory array
// plus an output head register, one write and one read per cycle.
module free_id_fifo #(
  parameter int DEPTH = pkt_id_manager_pkg::PKT_NUM,
  parameter int WIDTH = pkt_id_manager_pkg::PKT_AWIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level;
  logic [WIDTH-1:0] head;
  logic             head_valid;

  logic pop;
  logic refill;
  logic mem_empty;
  logic mem_rd;
  logic mem_wr;
  logic bypass;

  assign pop       = rd_en & head_valid;
  assign refill    = ~head_valid | pop;
  assign mem_empty = (level == {{AW{1'b0}}, head_valid});
  assign mem_rd    = refill & ~mem_empty;
  // a write into an empty store goes straight to the head
  assign bypass    = wr_en & refill & mem_empty;
  assign mem_wr    = wr_en & ~bypass;

  assign rd_data = head;
  assign empty   = ~head_valid;
  assign full    = (level == (AW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      head_valid <= 1'b0;
    end else begin
      assert (!(wr_en && full && !pop))
        else `HTERMINATE("free_id_fifo: write to full FIFO");
      if (mem_wr)
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0
                                             : wr_ptr + 1'b1;
      if (mem_rd)
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0
                                             : rd_ptr + 1'b1;
      if (wr_en && !pop)
        level <= level + 1'b1;
      else if (!wr_en && pop)
        level <= level - 1'b1;
      if (refill)
        head_valid <= mem_rd | bypass;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr)
      mem[wr_ptr] <= wr_data;
    if (mem_rd)
      head <= mem[rd_ptr];
    else if (bypass)
      head <= wr_data;
  end

endmodule

// File: rtl/pkt_id_manager.sv
// Packet-buffer free list: init fill, show-ahead alloc port,
// two round-robin free ports, occupancy count and error flag.
module pkt_id_manager #(
  parameter int PKT_NUM    = pkt_id_manager_pkg::PKT_NUM,
  parameter int PKT_AWIDTH = $clog2(PKT_NUM),
  parameter int INIT_DELAY = pkt_id_manager_pkg::INIT_DELAY
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  alloc_valid,
  output logic [PKT_AWIDTH-1:0] alloc_data,
  input  logic                  alloc_ready,
  input  logic                  free0_valid,
  input  logic [PKT_AWIDTH-1:0] free0_data,
  output logic                  free0_ready,
  input  logic                  free1_valid,
  input  logic [PKT_AWIDTH-1:0] free1_data,
  output logic                  free1_ready,
  output logic                  init_done,
  output logic [PKT_AWIDTH:0]   free_count,
  output logic                  free_err
);

  localparam logic [1:0] WAIT_STABLE = 2'd0;
  localparam logic [1:0] INIT        = 2'd1;
  localparam logic [1:0] RUN         = 2'd2;

  logic [1:0]            state;
  logic [31:0]           cnt;
  logic [PKT_AWIDTH-1:0] init_k;
  logic [PKT_NUM-1:0]    bitmap;
  logic                  rr_last;

  logic                  run;
  logic                  filling;
  logic                  g0;
  logic                  g1;
  logic                  acc;
  logic [PKT_AWIDTH-1:0] fid;
  logic                  in_range;
  logic                  free_ok;
  logic                  pop;
  logic                  wr_en;
  logic [PKT_AWIDTH-1:0] wr_data;
  logic                  fifo_empty;
  logic                  fifo_full;

  assign run     = (state == RUN);
  assign filling = (state == INIT);

  // on contention the port that did not win last time goes first
  assign g0 = free0_valid & (~free1_valid | rr_last);
  assign g1 = free1_valid & (~free0_valid | ~rr_last);

  assign free0_ready = run & g0;
  assign free1_ready = run & g1;
  assign acc         = run & (g0 | g1);
  assign fid         = g0 ? free0_data : free1_data;

  if (PKT_NUM == (2 ** PKT_AWIDTH)) begin : g_pow2
    assign in_range = 1'b1;
  end else begin : g_npow2
    assign in_range = (32'(fid) < PKT_NUM);
  end

  assign free_ok = acc & in_range & bitmap[fid];

  assign alloc_valid = run & ~fifo_empty;
  assign pop         = alloc_valid & alloc_ready;
  assign init_done   = run;

  assign wr_en   = filling | free_ok;
  assign wr_data = filling ? init_k : fid;

  free_id_fifo #(
    .DEPTH (PKT_NUM),
    .WIDTH (PKT_AWIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (alloc_data),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= WAIT_STABLE;
      cnt    <= '0;
      init_k <= '0;
    end else begin
      case (state)
        WAIT_STABLE: begin
          cnt <= cnt + 1'b1;
          if (cnt == 32'(INIT_DELAY))
            state <= INIT;
        end
        INIT: begin
          init_k <= init_k + 1'b1;
          if (init_k == PKT_AWIDTH'(PKT_NUM - 1))
            state <= RUN;
        end
        default: state <= state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bitmap     <= '0;
      rr_last    <= 1'b1;
      free_count <= '0;
      free_err   <= 1'b0;
    end else begin
      // a full list means no ID can be outstanding
      assert (!(fifo_full && (|bitmap)))
        else `HTERMINATE("pkt_id_manager: bitmap/list mismatch");
      if (acc)
        rr_last <= g1;
      if (pop)
        bitmap[alloc_data] <= 1'b1;
      if (free_ok)
        bitmap[fid] <= 1'b0;
      if (acc && !free_ok)
        free_err <= 1'b1;
      free_count <= free_count
                  + {{PKT_AWIDTH{1'b0}}, wr_en}
                  - {{PKT_AWIDTH{1'b0}}, pop};
    end
  end

endmodule

// File: tb/tb_pkt_id_manager.sv
// Directed bench for pkt_id_manager: init, drain, arbitration,
// refill latency, double free and mid-run reset.
module tb_pkt_id_manager;

  localparam int N   = 512;
  localparam int AW  = 9;
  localparam int LAT = 50 + 1 + 512;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          alloc_valid;
  logic [AW-1:0] alloc_data;
  logic          alloc_ready = 1'b0;
  logic          free0_valid = 1'b0;
  logic [AW-1:0] free0_data  = '0;
  logic          free0_ready;
  logic          free1_valid = 1'b0;
  logic [AW-1:0] free1_data  = '0;
  logic          free1_ready;
  logic          init_done;
  logic [AW:0]   free_count;
  logic          free_err;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pkt_id_manager dut (
    .clk         (clk),
    .rst         (rst),
    .alloc_valid (alloc_valid),
    .alloc_data  (alloc_data),
    .alloc_ready (alloc_ready),
    .free0_valid (free0_valid),
    .free0_data  (free0_data),
    .free0_ready (free0_ready),
    .free1_valid (free1_valid),
    .free1_data  (free1_data),
    .free1_ready (free1_ready),
    .init_done   (init_done),
    .free_count  (free_count),
    .free_err    (free_err)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 2000) begin
      tick();
      n++;
    end
  endtask

  task automatic free_one(input bit port, input int id, input string tag);
    if (port) begin
      free1_valid = 1'b1;
      free1_data  = AW'(id);
    end else begin
      free0_valid = 1'b1;
      free0_data  = AW'(id);
    end
    #1;
    chk(tag, port ? int'(free1_ready) : int'(free0_ready), 1);
    tick();
    free0_valid = 1'b0;
    free1_valid = 1'b0;
  endtask

  task automatic alloc_one(input int id, input string tag);
    chk(tag, alloc_valid ? int'(alloc_data) : -1, id);
    alloc_ready = 1'b1;
    tick();
    alloc_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int q0[$];
    int q1[$];
    int exp_port[4];
    logic r0, r1;

    free0_valid = 1'b1;
    free1_valid = 1'b1;
    repeat (3) tick();
    chk("rst_alloc_valid", alloc_valid, 0);
    chk("rst_free0_ready", free0_ready, 0);
    chk("rst_free1_ready", free1_ready, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_free_count", free_count, 0);
    chk("rst_free_err", free_err, 0);
    free0_valid = 1'b0;
    free1_valid = 1'b0;
    rst = 1'b0;

    wait_init(n);
    chk("init_latency", n, LAT);
    chk("init_count", free_count, N);
    chk("init_err", free_err, 0);

    alloc_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("drain_id%0d", i),
          alloc_valid ? int'(alloc_data) : -1, i);
      tick();
    end
    alloc_ready = 1'b0;
    chk("drain_valid", alloc_valid, 0);
    chk("drain_count", free_count, 0);
    chk("drain_err", free_err, 0);

    q0 = '{10, 11};
    q1 = '{20, 21};
    exp_port = '{0, 1, 0, 1};
    for (int c = 0; c < 4; c++) begin
      free0_valid = (q0.size() > 0);
      free0_data  = (q0.size() > 0) ? AW'(q0[0]) : '0;
      free1_valid = (q1.size() > 0);
      free1_data  = (q1.size() > 0) ? AW'(q1[0]) : '0;
      #1;
      r0 = free0_ready;
      r1 = free1_ready;
      chk($sformatf("arb_rdy0_c%0d", c), r0, exp_port[c] == 0);
      chk($sformatf("arb_rdy1_c%0d", c), r1, exp_port[c] == 1);
      tick();
      if (r0 && q0.size() > 0) void'(q0.pop_front());
      if (r1 && q1.size() > 0) void'(q1.pop_front());
    end
    free0_valid = 1'b0;
    free1_valid = 1'b0;
    chk("arb_count", free_count, 4);
    alloc_one(10, "arb_order0");
    alloc_one(20, "arb_order1");
    alloc_one(11, "arb_order2");
    alloc_one(21, "arb_order3");
    chk("arb_empty", alloc_valid, 0);

    free_one(0, 7, "refill_rdy");
    chk("refill_valid", alloc_valid, 1);
    chk("refill_data", alloc_data, 7);
    chk("refill_count", free_count, 1);

    free_one(1, 5, "dbl_first_rdy");
    chk("dbl_first_err", free_err, 0);
    chk("dbl_first_count", free_count, 2);
    free_one(0, 5, "dbl_second_rdy");
    chk("dbl_second_err", free_err, 1);
    chk("dbl_second_count", free_count, 2);
    alloc_one(7, "dbl_alloc0");
    alloc_one(5, "dbl_alloc1");
    chk("dbl_once", alloc_valid, 0);
    chk("dbl_sticky", free_err, 1);
    chk("dbl_count", free_count, 0);

    for (int i = 0; i < 100; i++)
      free_one(0, 100 + i, $sformatf("fill_rdy%0d", i));
    chk("pre_rst_count", free_count, 100);
    chk("pre_rst_err", free_err, 1);

    rst = 1'b1;
    tick();
    chk("mid_rst_alloc_valid", alloc_valid, 0);
    chk("mid_rst_init_done", init_done, 0);
    chk("mid_rst_count", free_count, 0);
    chk("mid_rst_err", free_err, 0);
    chk("mid_rst_free0_ready", free0_ready, 0);
    rst = 1'b0;

    wait_init(n);
    chk("reinit_latency", n, LAT);
    chk("reinit_count", free_count, N);
    chk("reinit_err", free_err, 0);
    alloc_one(0, "reinit_first");
    alloc_one(1, "reinit_second");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
